// File: rtl/seq_detect_pkg.sv
// Shared defaults and sizing helpers for the parameterised serial pattern detector.
package seq_detect_pkg;

  localparam int          DEF_MAX_LEN     = 8;
  localparam int          DEF_CNT_W       = 8;
  localparam logic [15:0] DEF_RST_PATTERN = 16'h000B;
  localparam int          DEF_RST_LEN     = 4;
  localparam bit          DEF_RST_OVERLAP = 1'b1;

  // Width needed to hold a length value 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                  MAX_LEN     = DEF_MAX_LEN,
  parameter int                  CNT_W       = DEF_CNT_W,
  parameter logic [MAX_LEN-1:0]  RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
  parameter int                  RST_LEN     = DEF_RST_LEN,
  parameter bit                  RST_OVERLAP = DEF_RST_OVERLAP
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           x,
  input  logic                           x_valid,
  input  logic                           cfg_load,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [len_width(MAX_LEN)-1:0]  cfg_len,
  input  logic                           cfg_overlap,
  output logic                           op,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           cfg_err
);

  localparam int LW = len_width(MAX_LEN);

  logic [MAX_LEN-1:0] pattern;
  logic [LW-1:0]      len;
  logic               overlap;
  logic [MAX_LEN-1:0] hist;
  logic [LW-1:0]      fill;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [LW-1:0]      fill_inc;
  logic [MAX_LEN-1:0] mask;
  logic               match;

  // Data path: x is consumed on every edge where x_valid is high; there is no
  // ready/back-pressure, and a concurrent cfg_load discards the sample.
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], x};
    fill_inc = (fill >= len) ? len : fill + LW'(1);
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    match = x_valid && !cfg_load && !cfg_err && (fill_inc == len) &&
            (((hist_nxt ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= RST_PATTERN;
      len     <= LW'(RST_LEN);
      overlap <= RST_OVERLAP;
      cfg_err <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      op      <= 1'b0;
    end else if (cfg_load) begin
      pattern <= cfg_pattern;
      len     <= cfg_len;
      overlap <= cfg_overlap;
      cfg_err <= (cfg_len == '0) || (cfg_len > LW'(MAX_LEN));
      hist    <= '0;
      fill    <= '0;
      op      <= 1'b0;
    end else if (x_valid) begin
      hist <= hist_nxt;
      // Non-overlap restarts the fill so the next match needs len fresh bits.
      fill <= (match && !overlap) ? '0 : fill_inc;
      op   <= match;
    end else begin
      op <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cfg_load),
    .inc   (match),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default and narrow-counter instances.
module tb_seq_detect_param;

  logic       clk;
  logic       rst_n;
  logic       x;
  logic       x_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       op;
  logic [7:0] match_cnt;
  logic       cfg_err;

  logic       rst2_n;
  logic       x2;
  logic       x2_valid;
  logic       cfg2_load;
  logic [7:0] cfg2_pattern;
  logic [3:0] cfg2_len;
  logic       cfg2_overlap;
  logic       op2;
  logic [1:0] match2_cnt;
  logic       cfg2_err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  seq_detect_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .x_valid     (x_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .op          (op),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  seq_detect_param #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst2_n),
    .x           (x2),
    .x_valid     (x2_valid),
    .cfg_load    (cfg2_load),
    .cfg_pattern (cfg2_pattern),
    .cfg_len     (cfg2_len),
    .cfg_overlap (cfg2_overlap),
    .op          (op2),
    .match_cnt   (match2_cnt),
    .cfg_err     (cfg2_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver tasks: drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input logic b, input logic v);
    @(negedge clk);
    x       = b;
    x_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic b);
    @(negedge clk);
    x2       = b;
    x2_valid = 1'b1;
    @(posedge clk);
    #1;
    x2_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                      input logic v, input logic b);
    @(negedge clk);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    x_valid     = v;
    x           = b;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    x_valid  = 1'b0;
  endtask

  // Feed n valid bits (MSB first) and check op after each against exp_op.
  task automatic run_stream(input string tag, input logic [15:0] bits, input int n,
                            input logic [15:0] exp_op);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1);
      check($sformatf("%s_op%0d", tag, n - i), {31'd0, op}, {31'd0, exp_op[i]});
    end
    x_valid = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b1;
    rst2_n       = 1'b1;
    x            = 1'b0;
    x_valid      = 1'b0;
    cfg_load     = 1'b0;
    cfg_pattern  = '0;
    cfg_len      = '0;
    cfg_overlap  = 1'b0;
    x2           = 1'b0;
    x2_valid     = 1'b0;
    cfg2_load    = 1'b0;
    cfg2_pattern = '0;
    cfg2_len     = '0;
    cfg2_overlap = 1'b0;
    #2;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    #1;
    check("rst_op",      {31'd0, op},      32'd0);
    check("rst_cnt",     {24'd0, match_cnt}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst2_cnt",    {30'd0, match2_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // Reset defaults: 1011, overlap on
    run_stream("ovl", 16'b1011011, 7, 16'b0001001);
    check("ovl_cnt", {24'd0, match_cnt}, 32'd2);

    // Non-overlap mode
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0);
    check("nov_load_cnt", {24'd0, match_cnt}, 32'd0);
    run_stream("nov", 16'b1011011, 7, 16'b0001000);
    check("nov_cnt", {24'd0, match_cnt}, 32'd1);

    // x_valid gaps with x toggling
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1); check("gap_v1", {31'd0, op}, 32'd0);
    step(1'b1, 1'b0); check("gap_g1", {31'd0, op}, 32'd0);
    step(1'b0, 1'b1); check("gap_v2", {31'd0, op}, 32'd0);
    step(1'b0, 1'b0); check("gap_g2", {31'd0, op}, 32'd0);
    step(1'b1, 1'b0); check("gap_g3", {31'd0, op}, 32'd0);
    step(1'b1, 1'b1); check("gap_v3", {31'd0, op}, 32'd0);
    step(1'b0, 1'b0); check("gap_g4", {31'd0, op}, 32'd0);
    step(1'b1, 1'b1); check("gap_v4", {31'd0, op}, 32'd1);
    step(1'b1, 1'b0); check("gap_g5", {31'd0, op}, 32'd0);
    check("gap_cnt", {24'd0, match_cnt}, 32'd1);

    // cfg_load wins over a simultaneous sample
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    load(8'b0000_0110, 4'd3, 1'b1, 1'b1, 1'b0);
    check("ldw_op",  {31'd0, op},       32'd0);
    check("ldw_cnt", {24'd0, match_cnt}, 32'd0);
    run_stream("ldw", 16'b110, 3, 16'b001);
    check("ldw_cnt2", {24'd0, match_cnt}, 32'd1);

    // Illegal lengths
    load(8'b0000_1011, 4'd0, 1'b1, 1'b0, 1'b0);
    check("len0_err", {31'd0, cfg_err}, 32'd1);
    run_stream("len0", 16'b1011, 4, 16'b0000);
    check("len0_cnt", {24'd0, match_cnt}, 32'd0);
    load(8'b0000_1011, 4'd9, 1'b1, 1'b0, 1'b0);
    check("len9_err", {31'd0, cfg_err}, 32'd1);
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0);
    check("legal_err", {31'd0, cfg_err}, 32'd0);
    run_stream("legal", 16'b1011, 4, 16'b0001);

    // Full-width pattern
    load(8'b1001_0110, 4'd8, 1'b1, 1'b0, 1'b0);
    run_stream("w8", 16'b1_1001_0110, 9, 16'b0_0000_0001);

    // Narrow counter saturates at 3
    step2(1'b1); step2(1'b0); step2(1'b1); step2(1'b1);
    check("sat_op1", {31'd0, op2}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step2(1'b0); step2(1'b1); step2(1'b1);
    end
    check("sat_op5", {31'd0, op2},       32'd1);
    check("sat_cnt", {30'd0, match2_cnt}, 32'd3);

    // Asynchronous reset mid-stream, between edges
    rst2_n = 1'b0;
    #2;
    check("arst_op",  {31'd0, op2},       32'd0);
    check("arst_cnt", {30'd0, match2_cnt}, 32'd0);
    @(negedge clk);
    rst2_n = 1'b1;
    step2(1'b0); check("arst_h1", {31'd0, op2}, 32'd0);
    step2(1'b1); check("arst_h2", {31'd0, op2}, 32'd0);
    step2(1'b1); check("arst_h3", {31'd0, op2}, 32'd0);

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameters SHALL be (name, default, meaning): MAX_LEN, 8, maximum pattern length in bits (2..16).
REQ-002 CNT_W, 8, match-counter width.
REQ-003 RST_PATTERN, 8'b0000_1011, pattern loaded at reset (low RST_LEN bits used).
REQ-004 RST_LEN, 4, pattern length loaded at reset.
REQ-005 RST_OVERLAP, 1, overlap mode loaded at reset.
REQ-006 Ports SHALL be (name, direction, width, meaning): clk, in, 1, single clock, all state on rising edge.
REQ-007 rst_n, in, 1, asynchronous active-low reset.
REQ-008 x, in, 1, serial data bit.
REQ-009 x_valid, in, 1, x sampled only when high.
REQ-010 cfg_load, in, 1, one-cycle strobe capturing cfg_pattern/cfg_len/cfg_overlap.
REQ-011 cfg_pattern, in, MAX_LEN, pattern; cfg_pattern[len-1] is first-received bit, [0] last.
REQ-012 cfg_len, in, $clog2(MAX_LEN)+1, pattern length.
REQ-013 cfg_overlap, in, 1, 1 = overlapping matches allowed.
REQ-014 op, out, 1, one-cycle match pulse.
REQ-015 match_cnt, out, CNT_W, saturating match count.
REQ-016 cfg_err, out, 1, active configuration illegal.

Function
REQ-017 Block SHALL hold history register hist (MAX_LEN bits) and fill count fill (0..len).
REQ-018 On a clk edge with x_valid=1 and cfg_load=0, hist SHALL shift left taking x into bit 0, and fill SHALL increment, saturating at len.
REQ-019 A match SHALL occur when updated fill equals len and updated hist[len-1:0] equals pattern[len-1:0].
REQ-020 op SHALL be registered: high for exactly the one cycle after the edge sampling the completing bit; low otherwise.
REQ-021 Overlap mode: fill SHALL stay at len after a match, so the next bit may complete another match.
REQ-022 Non-overlap mode: fill SHALL clear to 0 on the matching edge, so the next match needs len fresh bits.
REQ-023 x_valid=0 cycles SHALL leave hist, fill unchanged and op low; x is ignored.
REQ-024 match_cnt SHALL increment on each match and hold at all-ones (no wrap).
REQ-025 cfg_load=1 SHALL capture pattern, len, overlap, then clear hist, fill, op and match_cnt on the same edge.
REQ-026 cfg_load and x_valid together: cfg_load wins; the sample is discarded.
REQ-027 cfg_len=0 or cfg_len>MAX_LEN: cfg_err SHALL be set on the load edge; no match may occur until a legal load clears cfg_err.
REQ-028 Match latency from sampled completing bit to op SHALL be 1 clock; there is no back-pressure.

Reset
REQ-029 rst_n low SHALL immediately, without clk, force op=0, match_cnt=0, cfg_err=0, hist=0, fill=0.
REQ-030 rst_n low SHALL load pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP.
REQ-031 Reset release SHALL be effective at the first clk edge with rst_n high; partial history is never retained across reset.

Structure
REQ-032 Package seq_detect_pkg SHALL hold default constants (RST_PATTERN, RST_LEN, RST_OVERLAP) and the length-width function.
REQ-033 Saturating counter SHALL be the sub-module sat_counter (params W; ports clk, rst_n, clr, inc, q).
REQ-034 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-035 Reset defaults (1011, overlap); x_valid=1; x=1,0,1,1,0,1,1 -> op pulses after bits 4 and 7; match_cnt=2.
REQ-036 Load cfg_overlap=0, same stream -> op only after bit 4; match_cnt=1.
REQ-037 Stream 1,0,1,1 with x_valid=0 gaps and x toggling during gaps -> single op after last valid bit; no op in gaps.
REQ-038 After 1,1 sampled, cfg_load 3'b110/len 3 with x_valid=1, x=0 the same edge -> sample discarded, match_cnt=0; then 1,1,0 -> op once.
REQ-039 cfg_len=0 load -> cfg_err=1, 1,0,1,1 gives no op; legal load then clears cfg_err.
REQ-040 CNT_W=2, five matches -> match_cnt=3; rst_n low between edges mid-stream -> op, match_cnt 0 immediately.
